// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of the single-port RAM command interface
// between two transaction masters, with read timeout reporting.
module ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 op0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] wdata0,
  output logic                 ack0,
  output logic [ADDR_SIZE-1:0] rdata0,
  output logic                 err0,
  input  logic                 req1,
  input  logic                 op1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [ADDR_SIZE-1:0] wdata1,
  output logic                 ack1,
  output logic [ADDR_SIZE-1:0] rdata1,
  output logic                 err1,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               r_state;
  logic                 r_last;
  logic                 r_gnt;
  logic                 r_op;
  logic [ADDR_SIZE-1:0] r_wdata;
  logic [TW-1:0]        r_timer;
  logic [ADDR_SIZE+1:0] r_din;
  logic                 r_rx;
  logic                 r_ack0;
  logic                 r_ack1;
  logic                 r_err0;
  logic                 r_err1;
  logic [ADDR_SIZE-1:0] r_rdata0;
  logic [ADDR_SIZE-1:0] r_rdata1;
  logic                 r_busy;

  logic                 w_any;
  logic                 w_pick1;
  logic                 w_op;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [ADDR_SIZE-1:0] w_wdata;
  logic                 w_tmo;

  // On contention the requester not served last wins.
  assign w_any   = req0 | req1;
  assign w_pick1 = req1 & (~req0 | ~r_last);
  assign w_op    = w_pick1 ? op1 : op0;
  assign w_addr  = w_pick1 ? addr1 : addr0;
  assign w_wdata = w_pick1 ? wdata1 : wdata0;
  assign w_tmo   = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_op     <= 1'b0;
      r_wdata  <= '0;
      r_timer  <= '0;
      r_din    <= '0;
      r_rx     <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick1;
            r_op    <= w_op;
            r_wdata <= w_wdata;
            r_din   <= {(w_op ? 2'b10 : 2'b00), w_addr};
            r_rx    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_din   <= r_op ? {2'b11, {ADDR_SIZE{1'b0}}}
                          : {2'b01, r_wdata};
          r_timer <= '0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_rx  <= 1'b0;
          r_din <= '0;
          if (r_op) begin
            r_state <= S_WAIT;
          end else begin
            r_ack0  <= ~r_gnt;
            r_ack1  <= r_gnt;
            r_state <= S_DONE;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (ram_tx_valid || w_tmo) begin
            r_ack0  <= ~r_gnt;
            r_ack1  <= r_gnt;
            r_err0  <= ~ram_tx_valid & ~r_gnt;
            r_err1  <= ~ram_tx_valid & r_gnt;
            r_state <= S_DONE;
            if (r_gnt) r_rdata1 <= ram_tx_valid ? ram_dout : '0;
            else       r_rdata0 <= ram_tx_valid ? ram_dout : '0;
          end
        end
        S_DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_din      = r_din;
  assign ram_rx_valid = r_rx;
  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign err0         = r_err0;
  assign err1         = r_err1;
  assign rdata0       = r_rdata0;
  assign rdata1       = r_rdata1;
  assign busy         = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors with hand-computed expectations
// for the two-requester RAM command arbiter.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, op0, req1, op1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, err0, ack1, err1;
  logic [7:0] rdata0, rdata1;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hit;
    rst = 1'b1;
    req0 = 0; op0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; op1 = 0; addr1 = 0; wdata1 = 0;
    ram_dout = 0; ram_tx_valid = 0;
    tick; tick;
    rst = 1'b0;
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_rx", 32'(ram_rx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'({ack0, ack1, err0, err1}), 0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 0);

    // write from requester 0
    req0 = 1; op0 = 0; addr0 = 8'h3C; wdata0 = 8'hA5;
    tick;
    chk("wr_addr_din", 32'(ram_din), 32'h03C);
    chk("wr_addr_rx", 32'(ram_rx_valid), 1);
    chk("wr_busy", 32'(busy), 1);
    tick;
    chk("wr_data_din", 32'(ram_din), 32'h1A5);
    chk("wr_data_rx", 32'(ram_rx_valid), 1);
    tick;
    chk("wr_ack0", 32'({ack0, err0, ack1}), 32'b100);
    chk("wr_done_rx", 32'(ram_rx_valid), 0);
    req0 = 0;
    tick;
    chk("wr_ack_pulse", 32'(ack0), 0);
    chk("wr_idle", 32'(busy), 0);

    // read from requester 1, RAM answers in the first wait cycle
    req1 = 1; op1 = 1; addr1 = 8'h3C;
    tick;
    chk("rd_addr_din", 32'(ram_din), 32'h23C);
    tick;
    chk("rd_data_din", 32'(ram_din), 32'h300);
    chk("rd_data_rx", 32'(ram_rx_valid), 1);
    tick;
    chk("rd_wait_rx", 32'(ram_rx_valid), 0);
    ram_tx_valid = 1; ram_dout = 8'hA5;
    tick;
    ram_tx_valid = 0; ram_dout = 0; req1 = 0;
    chk("rd_ack1", 32'({ack1, err1, ack0}), 32'b100);
    chk("rd_rdata1", 32'(rdata1), 32'hA5);
    tick;
    chk("rd_ack_pulse", 32'(ack1), 0);
    chk("rd_hold", 32'(rdata1), 32'hA5);
    chk("rd_idle", 32'(busy), 0);

    // both requesting continuously from reset: 0,1,0,1 every 4 cycles
    rst = 1;
    req0 = 1; op0 = 0; wdata0 = 8'h11; addr0 = 8'h01;
    req1 = 1; op1 = 0; wdata1 = 8'h22; addr1 = 8'h02;
    tick;
    rst = 0;
    for (int n = 1; n <= 16; n++) begin
      tick;
      chk("rr_ack0", 32'(ack0), 32'(n == 3 || n == 11));
      chk("rr_ack1", 32'(ack1), 32'(n == 7 || n == 15));
      if (n % 4 == 2)
        chk("rr_din", 32'(ram_din), (n % 8 == 2) ? 32'h111 : 32'h122);
    end
    req0 = 0; req1 = 0;
    tick;
    chk("rr_idle", 32'(busy), 0);

    // read that never gets data
    req1 = 1; op1 = 1; addr1 = 8'h55;
    hit = 0;
    for (int n = 1; n <= 30; n++) begin
      tick;
      if (n == 2) req1 = 0;
      if (ack1 && hit == 0) begin
        hit = n;
        chk("to_err1", 32'(err1), 1);
        chk("to_rdata1", 32'(rdata1), 0);
        chk("to_ack0", 32'(ack0), 0);
      end
    end
    chk("to_cycle", 32'(hit), 19);
    chk("to_idle", 32'(busy), 0);

    // reset during DATA of a write
    req0 = 1; op0 = 0; addr0 = 8'h44; wdata0 = 8'h77;
    tick; tick;
    chk("ab_data_din", 32'(ram_din), 32'h177);
    rst = 1;
    tick;
    rst = 0;
    chk("ab_rx", 32'(ram_rx_valid), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ack", 32'({ack0, ack1}), 0);
    req1 = 1; op1 = 0; addr1 = 8'h66;
    tick;
    chk("ab_grant0", 32'(ram_din), 32'h044);
    tick; tick;
    chk("ab_ack0", 32'({ack0, ack1}), 32'b10);
    req0 = 0; req1 = 0;
    tick;
    tick;
    chk("ab_idle", 32'(busy), 0);

    // read on requester 0 so rdata0 holds a known value
    req0 = 1; op0 = 1; addr0 = 8'h10;
    tick; tick; tick;
    ram_tx_valid = 1; ram_dout = 8'h5A;
    tick;
    ram_tx_valid = 0; req0 = 0;
    chk("r0_rdata0", 32'(rdata0), 32'h5A);
    tick;

    // spurious tx_valid in idle
    ram_tx_valid = 1; ram_dout = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      tick;
      chk("sp_ack", 32'({ack0, ack1, busy}), 0);
    end
    ram_tx_valid = 0;
    chk("sp_rdata0", 32'(rdata0), 32'h5A);
    chk("sp_rdata1", 32'(rdata1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  always @(negedge clk) begin
    if (ack0 && ack1) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_overlap: got ack0=%0b ack1=%0b expected not both",
               ack0, ack1);
    end
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester controller that shares the single-port RAM's command interface (10-bit din, rx_valid, dout, tx_valid) between independent masters, e.g. the SPI slave path and a debug/host port. It accepts whole read/write transactions, arbitrates round-robin, and sequences them into the RAM's two-command protocol. Commands are address then data; reads then wait for tx_valid. Read data, or a timeout error, is returned to the granted requester.

Parameters:
ADDR_SIZE, 8, address/data payload width; ram_din width is ADDR_SIZE+2
TIMEOUT, 16, max cycles in WAIT_RD without ram_tx_valid before error (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req0  in  1  requester 0 transaction request; held with fields stable until ack0
op0  in  1  0=write, 1=read
addr0  in  ADDR_SIZE  RAM address
wdata0  in  ADDR_SIZE  write data (ignored for read)
ack0  out  1  one-cycle pulse: transaction 0 complete
rdata0  out  ADDR_SIZE  read data, valid when ack0=1 and op was read
err0  out  1  one-cycle pulse with ack0 on read timeout
req1/op1/addr1/wdata1/ack1/rdata1/err1  same for requester 1
ram_din  out  ADDR_SIZE+2  RAM command word {cmd[1:0], payload}
ram_rx_valid  out  1  RAM command strobe
ram_dout  in  ADDR_SIZE  RAM read data
ram_tx_valid  in  1  RAM read data valid
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ADDR, DATA, WAIT_RD, DONE. Outputs are Moore-decoded from the state register and registered fields; there is no combinational req->RAM path.
- Reset (rst=1 at a clock edge): state=IDLE, last_served=1 (req0 wins first), latched fields=0, all outputs 0 (ram_din=0, ram_rx_valid=0, ack*/err*=0, rdata*=0, busy=0), timer=0.
- Reset mid-transaction: abort with no ack/err. ram_rx_valid is low from the cycle after the reset edge.
- IDLE: if only one req is high, grant it. If both are high, grant the requester != last_served. Latch grant id, op, addr, wdata; go to ADDR. With no req, stay in IDLE; ram_din=0 and ram_rx_valid=0.
- ADDR: ram_rx_valid=1, ram_din={op?2'b10:2'b00, addr}; go to DATA.
- DATA: ram_rx_valid=1.
  - Write: ram_din={2'b01, wdata}; go to DONE.
  - Read: ram_din={2'b11, 0}; clear timer; go to WAIT_RD.
- WAIT_RD: ram_rx_valid=0, timer++.
  - If ram_tx_valid=1: capture ram_dout into rdata of the granted requester; go to DONE.
  - Else if timer==TIMEOUT-1: set pending error, rdata=0; go to DONE.
- DONE: ack of the granted requester=1 for exactly one cycle; err likewise if pending. Set last_served=grant id; go to IDLE.
- rdata holds its value until the next read completion for that requester.
- ram_tx_valid outside WAIT_RD is ignored.
- Requester inputs are sampled only in IDLE. Changes while busy have no effect.
- req still high in the cycle after ack is a new request, eligible in the next IDLE cycle. Round-robin then prefers the other requester if it is also requesting.
- Latency (req seen in IDLE at edge k):
  - ram_rx_valid high in cycles k+1 and k+2.
  - Write ack in cycle k+3.
  - Read with tx_valid in cycle k+3: ack in cycle k+4.
- Throughput: one transaction in flight. IDLE lasts at least 1 cycle between transactions.
- ack0 and ack1 are never high simultaneously.

Test Plan:
- Write req0 op=0 addr=8'h3C wdata=8'hA5 -> ram_din=10'h03C then 10'h1A5, rx_valid high 2 cycles, ack0 pulse 3 cycles after grant, err0=0.
- Read req1 addr=8'h3C; model RAM returns 8'hA5 with tx_valid 1 cycle after the 10'h300 command -> ram_din=10'h23C then 10'h300, rdata1=8'hA5 with ack1.
- req0 and req1 both high continuously from reset, both writes -> grants alternate 0,1,0,1; no ack overlap; each transaction exactly 4 cycles apart from the next.
- Read with RAM never asserting tx_valid, TIMEOUT=16 -> ack1 and err1 together after 16 WAIT_RD cycles, rdata1=0, busy returns low.
- rst pulsed during DATA of a write -> no ack, ram_rx_valid low the next cycle, busy=0, next simultaneous request grants req0.
- Spurious ram_tx_valid in IDLE with ram_dout=8'hFF -> rdata0/rdata1 unchanged, no ack.
